// File: rtl/reaction_ctrl.sv
// reaction_ctrl: sequencing controller for the reaction-timer game.
// Synchronises the start/react push-buttons, runs the game FSM
// (idle, arm, random wait, measure, result, high-score, foul), holds the
// your-time and high-score registers and drives LEDs and HEX display data.
// Optional build macro: FALSE_START_EN -- a react press during the random
// wait ends the round in FOUL instead of being ignored.
module reaction_ctrl #(
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter logic [15:0] HISCORE_INIT = 16'h9999
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset_n,
  input  logic        start_n,
  input  logic        react_n,
  input  logic        hiscore_clr,
  input  logic        ms_tick,
  input  logic [10:0] rand_delay,
  input  logic [15:0] meas_bcd,
  output logic        bcd_clr,
  output logic        bcd_en,
  output logic [9:0]  led,
  output logic [15:0] disp_bcd,
  output logic        disp_blank,
  output logic        new_record,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT    = 3'd2,
    S_MEASURE = 3'd3,
    S_RESULT  = 3'd4,
    S_HISCORE = 3'd5,
    S_FOUL    = 3'd6
  } state_t;

  localparam logic [11:0] MIN_DELAY = 12'(MIN_DELAY_MS);
  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [9:0]  LED_ALL   = 10'h3FF;
  localparam logic [9:0]  LED_REC   = 10'b1010101010;
  localparam logic [9:0]  LED_FOUL  = 10'b0101010101;

  state_t      state, next_state;

  // Button synchronisers: two metastability flops, one history flop and a
  // registered falling-edge pulse, so a press is seen 3 cycles after the pin.
  logic [1:0]  start_sync, react_sync;
  logic        start_prev, react_prev;
  logic        start_press, react_press;
  logic        react_released;

  // Wait-phase counter and its target in milliseconds.
  logic [11:0] target;
  logic [11:0] wait_cnt;
  logic        wait_done;

  logic [15:0] your_time;
  logic [15:0] hiscore;

  // FSM side-effect strobes for the datapath.
  logic        load_target;
  logic        cnt_inc;
  logic        capture;
  logic [15:0] capture_val;

  assign react_released = react_sync[1];
  // Counter compares after the increment so the round ends on the
  // target-th tick; a target of 0 ends on the first tick.
  assign wait_done = ({1'b0, wait_cnt} + 13'd1) >= {1'b0, target};
  assign state_o   = state;

  // Synchronise both buttons and generate single-cycle press pulses.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      start_sync  <= 2'b11;
      react_sync  <= 2'b11;
      start_prev  <= 1'b1;
      react_prev  <= 1'b1;
      start_press <= 1'b0;
      react_press <= 1'b0;
    end else begin
      start_sync  <= {start_sync[0], start_n};
      react_sync  <= {react_sync[0], react_n};
      start_prev  <= start_sync[1];
      react_prev  <= react_sync[1];
      start_press <= start_prev & ~start_sync[1];
      react_press <= react_prev & ~react_sync[1];
    end
  end

  // State register.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_state  = state;
    bcd_clr     = 1'b0;
    load_target = 1'b0;
    cnt_inc     = 1'b0;
    capture     = 1'b0;
    capture_val = meas_bcd;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          next_state = S_ARM;
          bcd_clr    = 1'b1;
        end
      end
      S_ARM: begin
        if (react_released) begin
          next_state  = S_WAIT;
          load_target = 1'b1;
        end
      end
      S_WAIT: begin
`ifdef FALSE_START_EN
        if (react_press) begin
          next_state = S_FOUL;
        end else if (ms_tick) begin
          cnt_inc = 1'b1;
          if (wait_done) begin
            next_state = S_MEASURE;
            bcd_clr    = 1'b1;
          end
        end
`else
        if (ms_tick) begin
          cnt_inc = 1'b1;
          if (wait_done) begin
            next_state = S_MEASURE;
            bcd_clr    = 1'b1;
          end
        end
`endif
      end
      S_MEASURE: begin
        // A press in the same cycle as the timeout wins; both capture the
        // same value because meas_bcd is already 9999 then.
        if (react_press) begin
          next_state  = S_RESULT;
          capture     = 1'b1;
          capture_val = meas_bcd;
        end else if (meas_bcd == BCD_MAX) begin
          next_state  = S_RESULT;
          capture     = 1'b1;
          capture_val = BCD_MAX;
        end
      end
      S_RESULT: begin
        if (react_press) begin
          next_state = S_HISCORE;
        end
      end
      S_HISCORE: begin
        if (react_press) begin
          next_state = S_IDLE;
        end
      end
`ifdef FALSE_START_EN
      S_FOUL: begin
        if (react_press) begin
          next_state = S_IDLE;
        end
      end
`endif
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state and result registers.
  always_comb begin
    bcd_en     = 1'b0;
    led        = 10'd0;
    disp_bcd   = 16'd0;
    disp_blank = 1'b0;
    case (state)
      S_MEASURE: begin
        bcd_en   = 1'b1;
        led      = LED_ALL;
        disp_bcd = meas_bcd;
      end
      S_RESULT: begin
        led      = new_record ? LED_REC : 10'd0;
        disp_bcd = your_time;
      end
      S_HISCORE: begin
        disp_bcd = hiscore;
      end
`ifdef FALSE_START_EN
      S_FOUL: begin
        disp_blank = 1'b1;
        led        = LED_FOUL;
      end
`endif
      default: begin
        led = 10'd0;
      end
    endcase
  end

  // Wait target latch and millisecond counter.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      target   <= 12'd0;
      wait_cnt <= 12'd0;
    end else if (load_target) begin
      target   <= MIN_DELAY + {1'b0, rand_delay};
      wait_cnt <= 12'd0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 12'd1;
    end
  end

  // Result capture, high-score compare/update and record flag. The compare
  // is made on the edge that enters RESULT so the record LEDs are valid
  // from the first RESULT cycle.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      your_time  <= 16'd0;
      hiscore    <= HISCORE_INIT;
      new_record <= 1'b0;
    end else begin
      if (capture) begin
        your_time <= capture_val;
        if (capture_val < hiscore) begin
          hiscore    <= capture_val;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end else if (next_state == S_IDLE) begin
        new_record <= 1'b0;
      end
      if (state == S_IDLE && hiscore_clr) begin
        hiscore <= HISCORE_INIT;
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: scoreboard bench for reaction_ctrl. Plays full games,
// counts ms ticks in the wait phase, exercises timeout, false start,
// mid-game reset and high-score clear.
module tb_reaction_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_n = 1'b1;
  logic        react_n = 1'b1;
  logic        hiscore_clr = 1'b0;
  logic        ms_tick = 1'b0;
  logic [10:0] rand_delay = 11'd0;
  logic [15:0] meas_bcd = 16'd0;
  logic        bcd_clr, bcd_en, disp_blank, new_record;
  logic [9:0]  led;
  logic [15:0] disp_bcd;
  logic [2:0]  state_o;

  always #10 clk = ~clk;

  reaction_ctrl dut (
    .MAX10_CLK1_50(clk),
    .reset_n(reset_n),
    .start_n(start_n),
    .react_n(react_n),
    .hiscore_clr(hiscore_clr),
    .ms_tick(ms_tick),
    .rand_delay(rand_delay),
    .meas_bcd(meas_bcd),
    .bcd_clr(bcd_clr),
    .bcd_en(bcd_en),
    .led(led),
    .disp_bcd(disp_bcd),
    .disp_blank(disp_blank),
    .new_record(new_record),
    .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] hs_model = 16'h9999;
  int          total = 0;
  int          bad = 0;
  int          clr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_start();
    @(negedge clk); start_n = 1'b0;
    repeat (6) @(negedge clk);
    start_n = 1'b1;
  endtask

  task automatic press_react();
    @(negedge clk); react_n = 1'b0;
    repeat (6) @(negedge clk);
    react_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick_once();
    @(negedge clk); ms_tick = 1'b1;
    #1 clr_cnt += int'(bcd_clr);
    @(negedge clk); ms_tick = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (state_o !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(state_o), 32'(s));
  endtask

  // Tick through WAIT until MEASURE; returns number of ticks issued.
  task automatic tick_to_measure(output int n);
    n = 0;
    clr_cnt = 0;
    while (state_o == 3'd2 && n < 5000) begin
      tick_once();
      n++;
    end
  endtask

  task automatic play_game(input logic [10:0] rd, input logic [15:0] res,
                           input bit timeout, input bit clr_in_result);
    int          n;
    logic        exp_nr;
    logic [15:0] got_v;
    rand_delay = rd;
    press_start();
    wait_state(3'd2, 50, "enter_wait");
    tick_to_measure(n);
    check("wait_ticks", 32'(n), 32'(500 + int'(rd)));
    check("bcd_clr_pulses", 32'(clr_cnt), 32'd1);
    check("measure_state", 32'(state_o), 32'd3);
    check("measure_led", 32'(led), 32'h3FF);
    check("measure_en", 32'(bcd_en), 32'd1);
    exp_nr = (res < hs_model);
    if (exp_nr) hs_model = res;
    exp_q.push_back(res);
    exp_q.push_back(hs_model);
    if (timeout) begin
      @(negedge clk); meas_bcd = 16'h9998;
      repeat (4) @(negedge clk);
      check("no_early_timeout", 32'(state_o), 32'd3);
      meas_bcd = 16'h9999;
    end else begin
      meas_bcd = res;
      press_react();
    end
    wait_state(3'd4, 20, "enter_result");
    got_v = exp_q.pop_front();
    check("result_disp", 32'(disp_bcd), 32'(got_v));
    check("result_nr", 32'(new_record), 32'(exp_nr));
    check("result_led", 32'(led), exp_nr ? 32'h2AA : 32'h0);
    check("result_en", 32'(bcd_en), 32'd0);
    if (clr_in_result) begin
      @(negedge clk); hiscore_clr = 1'b1;
      repeat (3) @(negedge clk);
      hiscore_clr = 1'b0;
    end
    press_react();
    wait_state(3'd5, 20, "enter_hiscore");
    got_v = exp_q.pop_front();
    check("hiscore_disp", 32'(disp_bcd), 32'(got_v));
    check("hiscore_led", 32'(led), 32'd0);
    check("hiscore_nr_held", 32'(new_record), 32'(exp_nr));
    press_react();
    wait_state(3'd0, 20, "back_idle");
    check("idle_nr_clear", 32'(new_record), 32'd0);
    check("idle_disp", 32'(disp_bcd), 32'd0);
    meas_bcd = 16'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_disp", 32'(disp_bcd), 32'd0);
    check("rst_en", 32'(bcd_en), 32'd0);
    check("rst_clr", 32'(bcd_clr), 32'd0);
    check("rst_nr", 32'(new_record), 32'd0);
    check("rst_blank", 32'(disp_blank), 32'd0);

    // Record game, then a slower game with a clear attempt in RESULT.
    play_game(11'd100, 16'h0250, 1'b0, 1'b0);
    play_game(11'($urandom_range(0, 300)), 16'h0312, 1'b0, 1'b1);
    // Timeout game.
    play_game(11'd0, 16'h9999, 1'b1, 1'b0);

    // React press at tick 10 of WAIT.
    rand_delay = 11'd0;
    press_start();
    wait_state(3'd2, 50, "foul_enter_wait");
    repeat (10) tick_once();
    press_react();
`ifdef FALSE_START_EN
    wait_state(3'd6, 20, "foul_state");
    check("foul_led", 32'(led), 32'h155);
    check("foul_blank", 32'(disp_blank), 32'd1);
    repeat (3) tick_once();
    check("foul_hold", 32'(state_o), 32'd6);
    check("foul_en", 32'(bcd_en), 32'd0);
    press_react();
    wait_state(3'd0, 20, "foul_exit");
    press_start();
    wait_state(3'd2, 50, "reenter_wait");
    tick_to_measure(n);
    check("wait_ticks_2", 32'(n), 32'd500);
`else
    repeat (5) @(negedge clk);
    check("no_foul_stay_wait", 32'(state_o), 32'd2);
    check("no_foul_blank", 32'(disp_blank), 32'd0);
    tick_to_measure(n);
    check("wait_ticks_after_ignored", 32'(n), 32'd490);
`endif
    check("pre_reset_measure", 32'(state_o), 32'd3);

    // Asynchronous reset in MEASURE.
    @(negedge clk); #3 reset_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_en", 32'(bcd_en), 32'd0);
    check("async_rst_led", 32'(led), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    hs_model = 16'h9999;
    @(negedge clk);

    // High score lost on reset; clear in RESULT ignored.
    play_game(11'd0, 16'h0300, 1'b0, 1'b1);
    // Clear in IDLE restores the initial high score.
    @(negedge clk); hiscore_clr = 1'b1;
    repeat (2) @(negedge clk);
    hiscore_clr = 1'b0;
    hs_model = 16'h9999;
    play_game(11'd0, 16'h0500, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #4000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
